// File: rtl/bw_turn_scheduler.sv
// bw_turn_scheduler
// Round sequencer for the two-player black-and-white card game. It decides
// which player leads each round, enforces lead-then-follow play order,
// validates card selections against the active player's hand, emits
// one-cycle load pulses toward the hand/card registers, holds a reveal
// interval and finally strobes the score update.
//
// Ports
//   clk           system clock
//   resetn        synchronous reset, active-high
//   start         level; rising edge starts a game (from IDLE or DONE)
//   play_req      level; rising edge submits sel
//   sel[8:0]      card-select switches, bit n = card n
//   p1_hand[8:0]  player 1 remaining cards (bit set = available)
//   p2_hand[8:0]  player 2 remaining cards
//   match_result  comparator: 01 P1 wins, 10 P2 wins, 00/11 draw
//   game_over     early-finish flag from the score logic
//   p1_load       one-cycle commit pulse for player 1
//   p2_load       one-cycle commit pulse for player 2
//   card_idx[3:0] encoded index of the committed card (valid with a load)
//   score_pulse   one-cycle score/round update strobe
//   active_p2     0 = P1 must play, 1 = P2 must play (LEAD/FOLLOW only)
//   leader_p2     current round leader
//   round_cnt     current round 1..ROUNDS, 0 in IDLE
//   err_invalid   one-cycle pulse on a rejected submission
//   phase[2:0]    IDLE=000 LEAD=001 FOLLOW=010 REVEAL=011 SCORE=100 DONE=101

module bw_turn_scheduler #(
  parameter int ROUNDS        = 9,
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       play_req,
  input  logic [8:0] sel,
  input  logic [8:0] p1_hand,
  input  logic [8:0] p2_hand,
  input  logic [1:0] match_result,
  input  logic       game_over,
  output logic       p1_load,
  output logic       p2_load,
  output logic [3:0] card_idx,
  output logic       score_pulse,
  output logic       active_p2,
  output logic       leader_p2,
  output logic [3:0] round_cnt,
  output logic       err_invalid,
  output logic [2:0] phase
);

  // The counter only ever holds REVEAL_CYCLES-1 down to 0.
  localparam int CW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [CW-1:0] REVEAL_LOAD = CW'(REVEAL_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LEAD   = 3'b001,
    S_FOLLOW = 3'b010,
    S_REVEAL = 3'b011,
    S_SCORE  = 3'b100,
    S_DONE   = 3'b101
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic            play_q, play_d;
  logic            arm_q, arm_d;
  logic [3:0]      round_q, round_d;
  logic            leader_q, leader_d;
  logic            active_q, active_d;
  logic            p1_load_q, p1_load_d;
  logic            p2_load_q, p2_load_d;
  logic            err_q, err_d;
  logic            score_q, score_d;
  logic [3:0]      card_idx_q, card_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            start_e;
  logic            play_e;
  logic            act_p2;
  logic [8:0]      act_hand;
  logic            sel_ok;

  function automatic logic [3:0] enc_idx(input logic [8:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // arm_q stays low for the first cycle after reset so the edge registers
  // can pick up a button that was already held; that press is not an event.
  always_comb begin
    start_e  = start & ~start_q & arm_q;
    play_e   = play_req & ~play_q & arm_q;
    act_p2   = (state_q == S_FOLLOW) ? ~leader_q : leader_q;
    act_hand = act_p2 ? p2_hand : p1_hand;
    sel_ok   = (sel != 9'd0) && ((sel & (sel - 9'd1)) == 9'd0) &&
               ((sel & act_hand) != 9'd0);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    start_d    = start;
    play_d     = play_req;
    arm_d      = 1'b1;
    round_d    = round_q;
    leader_d   = leader_q;
    card_idx_d = card_idx_q;
    cnt_d      = cnt_q;
    p1_load_d  = 1'b0;
    p2_load_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_e) begin
          state_d  = S_LEAD;
          round_d  = 4'd1;
          leader_d = 1'b0;
        end
      end
      S_LEAD, S_FOLLOW: begin
        if (play_e) begin
          if (sel_ok) begin
            p1_load_d  = ~act_p2;
            p2_load_d  = act_p2;
            card_idx_d = enc_idx(sel);
            if (state_q == S_LEAD) begin
              state_d = S_FOLLOW;
            end else begin
              state_d = S_REVEAL;
              cnt_d   = REVEAL_LOAD;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REVEAL: begin
        if (cnt_q == '0) begin
          state_d = S_SCORE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SCORE: begin
        if (match_result == 2'b01) leader_d = 1'b0;
        else if (match_result == 2'b10) leader_d = 1'b1;
        if ((round_q == LAST_ROUND) || game_over) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = S_LEAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobe tracks the SCORE phase exactly so both appear in the same cycle.
    score_d  = (state_d == S_SCORE);
    active_d = (state_d == S_FOLLOW) ? ~leader_d : leader_d;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      play_q     <= 1'b0;
      arm_q      <= 1'b0;
      round_q    <= 4'd0;
      leader_q   <= 1'b0;
      active_q   <= 1'b0;
      p1_load_q  <= 1'b0;
      p2_load_q  <= 1'b0;
      err_q      <= 1'b0;
      score_q    <= 1'b0;
      card_idx_q <= 4'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      play_q     <= play_d;
      arm_q      <= arm_d;
      round_q    <= round_d;
      leader_q   <= leader_d;
      active_q   <= active_d;
      p1_load_q  <= p1_load_d;
      p2_load_q  <= p2_load_d;
      err_q      <= err_d;
      score_q    <= score_d;
      card_idx_q <= card_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign p1_load     = p1_load_q;
  assign p2_load     = p2_load_q;
  assign card_idx    = card_idx_q;
  assign score_pulse = score_q;
  assign active_p2   = active_q;
  assign leader_p2   = leader_q;
  assign round_cnt   = round_q;
  assign err_invalid = err_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_bw_turn_scheduler.sv
// Self-checking bench for bw_turn_scheduler (ROUNDS=2, REVEAL_CYCLES=4).
// Directed stimulus pushes expected pulses into a scoreboard queue; a
// monitor pops one entry for every cycle a pulse output is high.

module tb_bw_turn_scheduler;

  localparam int ROUNDS = 2;
  localparam int REVEAL = 4;

  localparam logic [3:0] K_P1    = 4'b0001;
  localparam logic [3:0] K_P2    = 4'b0010;
  localparam logic [3:0] K_ERR   = 4'b0100;
  localparam logic [3:0] K_SCORE = 4'b1000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       play_req;
  logic [8:0] sel;
  logic [8:0] p1_hand;
  logic [8:0] p2_hand;
  logic [1:0] match_result;
  logic       game_over;
  logic       p1_load;
  logic       p2_load;
  logic [3:0] card_idx;
  logic       score_pulse;
  logic       active_p2;
  logic       leader_p2;
  logic [3:0] round_cnt;
  logic       err_invalid;
  logic [2:0] phase;

  typedef struct packed {
    logic [3:0] kind;
    logic [3:0] idx;
    logic [2:0] ph;
    logic [3:0] rnd;
    logic       ld;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stop_mon = 1'b0;

  always #5 clk = ~clk;

  bw_turn_scheduler #(
    .ROUNDS(ROUNDS),
    .REVEAL_CYCLES(REVEAL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .play_req(play_req),
    .sel(sel),
    .p1_hand(p1_hand),
    .p2_hand(p2_hand),
    .match_result(match_result),
    .game_over(game_over),
    .p1_load(p1_load),
    .p2_load(p2_load),
    .card_idx(card_idx),
    .score_pulse(score_pulse),
    .active_p2(active_p2),
    .leader_p2(leader_p2),
    .round_cnt(round_cnt),
    .err_invalid(err_invalid),
    .phase(phase)
  );

  // Scoreboard monitor: every cycle with a pulse high consumes one entry.
  initial begin
    exp_t       e;
    logic [3:0] k;
    bit         bad;
    forever begin
      @(negedge clk);
      if (!stop_mon) begin
        k = {score_pulse, err_invalid, p2_load, p1_load};
        if (k != 4'd0) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_pulse: got pulses=%b phase=%0d, required no pulse", k, phase);
          end else begin
            e = exp_q.pop_front();
            bad = (k != e.kind) || (phase != e.ph) || (round_cnt != e.rnd) ||
                  (leader_p2 != e.ld) ||
                  ((e.kind[1:0] != 2'b00) && (card_idx != e.idx));
            if (bad) begin
              miscompares++;
              $display("[TB] FAIL pulse: got kind=%b idx=%0d phase=%0d round=%0d leader=%0d, required kind=%b idx=%0d phase=%0d round=%0d leader=%0d",
                       k, card_idx, phase, round_cnt, leader_p2,
                       e.kind, e.idx, e.ph, e.rnd, e.ld);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectPulse(input logic [3:0] kind, input logic [3:0] idx,
                             input logic [2:0] ph, input logic [3:0] rnd,
                             input logic ld);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.ph   = ph;
    e.rnd  = rnd;
    e.ld   = ld;
    exp_q.push_back(e);
  endtask

  // One press-and-release of the play button with the given selection.
  task automatic applyStimulus(input logic [8:0] s);
    sel      = s;
    play_req = 1'b1;
    tick(1);
    play_req = 1'b0;
    tick(1);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] ph,
                             input logic [3:0] rnd, input logic ld,
                             input logic chk_act, input logic act);
    vectors++;
    if ((phase != ph) || (round_cnt != rnd) || (leader_p2 != ld) ||
        (chk_act && (active_p2 != act))) begin
      miscompares++;
      $display("[TB] FAIL %s: got phase=%0d round=%0d leader=%0d active=%0d, required phase=%0d round=%0d leader=%0d active=%0d",
               name, phase, round_cnt, leader_p2, active_p2, ph, rnd, ld, act);
    end
  endtask

  task automatic waitRoundEnd(input string name);
    int n;
    n = 0;
    while (!((phase == 3'b001) || (phase == 3'b101)) && (n < 20)) begin
      tick(1);
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("[TB] FAIL %s: got phase=%0d after %0d cycles, required LEAD or DONE", name, phase, n);
    end
  endtask

  task automatic doResetStart();
    resetn = 1'b1;
    tick(2);
    resetn = 1'b0;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    resetn       = 1'b1;
    start        = 1'b0;
    play_req     = 1'b0;
    sel          = 9'd0;
    p1_hand      = 9'h1FF;
    p2_hand      = 9'h1FF;
    match_result = 2'b00;
    game_over    = 1'b0;

    // Reset and start
    tick(2);
    checkOutput("reset_state", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    tick(2);
    checkOutput("idle_after_reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("start_to_lead", 3'd1, 4'd1, 1'b0, 1'b1, 1'b0);

    // Full round, P2 wins
    match_result = 2'b10;
    expectPulse(K_P1, 4'd4, 3'd2, 4'd1, 1'b0);
    applyStimulus(9'h010);
    checkOutput("follow_phase", 3'd2, 4'd1, 1'b0, 1'b1, 1'b1);
    expectPulse(K_P2, 4'd2, 3'd3, 4'd1, 1'b0);
    expectPulse(K_SCORE, 4'd0, 3'd4, 4'd1, 1'b0);
    applyStimulus(9'h004);
    checkOutput("reveal_cycle2", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("reveal_cycle3", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("reveal_cycle4", 3'd3, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("score_phase", 3'd4, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("round2_p2_leads", 3'd1, 4'd2, 1'b1, 1'b1, 1'b1);

    // Invalid submissions in LEAD
    doResetStart();
    p1_hand = 9'h1EF;
    expectPulse(K_ERR, 4'd0, 3'd1, 4'd1, 1'b0);
    expectPulse(K_ERR, 4'd0, 3'd1, 4'd1, 1'b0);
    expectPulse(K_ERR, 4'd0, 3'd1, 4'd1, 1'b0);
    applyStimulus(9'h010);
    applyStimulus(9'h003);
    applyStimulus(9'h000);
    checkOutput("lead_after_errs", 3'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    expectPulse(K_P1, 4'd0, 3'd2, 4'd1, 1'b0);
    applyStimulus(9'h001);
    p1_hand = 9'h1FF;
    match_result = 2'b00;
    expectPulse(K_P2, 4'd8, 3'd3, 4'd1, 1'b0);
    expectPulse(K_SCORE, 4'd0, 3'd4, 4'd1, 1'b0);
    applyStimulus(9'h100);
    waitRoundEnd("round1_end");
    checkOutput("round2_after_draw", 3'd1, 4'd2, 1'b0, 1'b1, 1'b0);

    // Held button: one commit only
    sel      = 9'h002;
    play_req = 1'b1;
    expectPulse(K_P1, 4'd1, 3'd2, 4'd2, 1'b0);
    tick(10);
    checkOutput("held_no_follow", 3'd2, 4'd2, 1'b0, 1'b1, 1'b1);
    play_req = 1'b0;
    tick(2);
    checkOutput("released_still_follow", 3'd2, 4'd2, 1'b0, 1'b1, 1'b1);
    expectPulse(K_P2, 4'd5, 3'd3, 4'd2, 1'b0);
    expectPulse(K_SCORE, 4'd0, 3'd4, 4'd2, 1'b0);
    applyStimulus(9'h020);
    waitRoundEnd("round2_end");
    checkOutput("done_after_rounds", 3'd5, 4'd2, 1'b0, 1'b0, 1'b0);

    // DONE ignores play; start+play restarts without a commit
    applyStimulus(9'h001);
    checkOutput("done_holds", 3'd5, 4'd2, 1'b0, 1'b0, 1'b0);
    sel      = 9'h001;
    start    = 1'b1;
    play_req = 1'b1;
    tick(1);
    start    = 1'b0;
    play_req = 1'b0;
    checkOutput("restart_play_ignored", 3'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    tick(1);

    // Early finish via game_over
    game_over    = 1'b1;
    match_result = 2'b11;
    expectPulse(K_P1, 4'd0, 3'd2, 4'd1, 1'b0);
    applyStimulus(9'h001);
    expectPulse(K_P2, 4'd1, 3'd3, 4'd1, 1'b0);
    expectPulse(K_SCORE, 4'd0, 3'd4, 4'd1, 1'b0);
    applyStimulus(9'h002);
    waitRoundEnd("game_over_end");
    checkOutput("game_over_done", 3'd5, 4'd1, 1'b0, 1'b0, 1'b0);
    game_over = 1'b0;

    // Mid-game reset during REVEAL with the counter at 2
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("restart_lead", 3'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    expectPulse(K_P1, 4'd3, 3'd2, 4'd1, 1'b0);
    applyStimulus(9'h008);
    expectPulse(K_P2, 4'd6, 3'd3, 4'd1, 1'b0);
    applyStimulus(9'h040);
    resetn = 1'b1;
    tick(1);
    checkOutput("mid_reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    tick(10);
    checkOutput("post_reset_idle", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Start held across reset must not start a game
    resetn = 1'b1;
    start  = 1'b1;
    tick(2);
    resetn = 1'b0;
    tick(4);
    checkOutput("held_start_ignored", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("start_after_release", 3'd1, 4'd1, 1'b0, 1'b1, 1'b0);

    tick(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missing_pulses: got %0d expected pulses outstanding, required 0", exp_q.size());
    end
    stop_mon = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bw_turn_scheduler.md
# bw_turn_scheduler

Round sequencer for the two-player black-and-white card game. It decides which player leads each round and enforces the lead-then-follow play order. It validates each card selection against the player's remaining hand, issues single-cycle load pulses to the hand/card registers, holds a reveal interval, and then emits the score-update pulse. It sits between the debounced button/switch inputs and the card, comparator and score datapath, and replaces ad-hoc per-player turn states in the top-level FSM.

## Interface
- `ROUNDS`, default 9: number of rounds in a game.
- `REVEAL_CYCLES`, default 50_000_000: clock cycles in REVEAL; minimum 1.
- `clk` input 1: system clock.
- `resetn` input 1: synchronous reset, active-high.
- `start` input 1: level; its rising edge starts a game.
- `play_req` input 1: level play button; its rising edge submits `sel`.
- `sel` input 9: card-select switches, bit n = card n.
- `p1_hand`, `p2_hand` input 9 each: remaining cards, bit set = card available.
- `match_result` input 2: comparator output. 01 = P1 wins; 10 = P2 wins; 00 or 11 = draw.
- `game_over` input 1: early-finish flag from the score logic.
- `p1_load`, `p2_load` output 1 each: one-cycle commit pulse for that player.
- `card_idx` output 4: encoded index (0–8) of the committed card. Valid while a load pulse is high.
- `score_pulse` output 1: one-cycle score/round update strobe.
- `active_p2` output 1: 0 = P1 must play, 1 = P2 must play. Meaningful in LEAD/FOLLOW only.
- `leader_p2` output 1: current round leader.
- `round_cnt` output 4: current round, 1..ROUNDS; 0 in IDLE.
- `err_invalid` output 1: one-cycle pulse on a rejected submission.
- `phase` output 3: IDLE=000, LEAD=001, FOLLOW=010, REVEAL=011, SCORE=100, DONE=101.

## Operation
- **Edge detection.** Registered copies `start_q` and `play_q` are kept. `start_e = start & ~start_q`; `play_e = play_req & ~play_q`. Holding a button produces exactly one event.
- **Valid submission.** `sel` is exactly one-hot, and `sel & hand_of_active` is nonzero. Zero bits or multiple bits set are invalid.
- **IDLE.** All pulses 0, `round_cnt=0`, `leader_p2=0`.
  - On `start_e`: go to LEAD, `round_cnt=1`, `leader_p2=0`.
- **LEAD.** `active_p2 = leader_p2`.
  - `play_e` with a valid submission: pulse the active player's load, latch `card_idx`, go to FOLLOW.
  - `play_e` with an invalid submission: pulse `err_invalid`, stay in LEAD.
- **FOLLOW.** `active_p2 = ~leader_p2`. Same validation as LEAD.
  - Valid submission: pulse load, go to REVEAL, load the reveal counter with `REVEAL_CYCLES-1`.
- **REVEAL.** Decrement the counter each cycle. When it reaches 0, go to SCORE.
  - `play_e` is ignored (no error pulse).
- **SCORE** (exactly one cycle). `score_pulse=1`; sample `match_result`.
  - Winner becomes the leader: 01 → `leader_p2=0`; 10 → `leader_p2=1`; draw leaves it unchanged.
  - If `round_cnt==ROUNDS` or `game_over`: go to DONE, `round_cnt` holds.
  - Otherwise `round_cnt+1` and go to LEAD.
- **DONE.** Outputs hold, pulses 0.
  - On `start_e`: same action as from IDLE (new game).
- `start_e` outside IDLE/DONE is ignored.
- `resetn` overrides everything in every state:
  - go to IDLE;
  - all outputs and counters go to 0, edge registers clear to 0, `card_idx=0`.

## Timing
- All outputs are registered.
- Load, `err_invalid` and `score_pulse` are high for exactly one cycle.
- Submission latency: a `play_e` sampled at edge k drives load/`err_invalid` high during cycle k+1. `phase` updates at the same edge.
- `sel` and hands are sampled at the same edge as `play_e`; later changes do not affect the committed `card_idx`.
- FOLLOW→SCORE spans exactly `REVEAL_CYCLES` cycles in REVEAL. `score_pulse` is high the cycle `phase=100`.
- `match_result` must be stable from the cycle after the second load until SCORE. The comparator is combinational on registered hands, so this holds.
- Simultaneous events:
  - `play_e` and `start_e` in IDLE/DONE: start acts, play is ignored.
  - `resetn` with any event: reset wins.
- A button already held when reset deasserts does not generate an event. The edge registers capture the level on the first post-reset cycle because they are cleared to 0 only during reset; a press is registered only after a release.

## Test plan
1. **Reset and start.** Assert `resetn` 2 cycles, then pulse `start`. Expect `phase` 000→001, `round_cnt=1`, `leader_p2=0`, all pulses 0.
2. **Full round**, `REVEAL_CYCLES=4`, both hands 1FF.
   - P1 `sel=9'h010`: `p1_load` for 1 cycle, `card_idx=4`.
   - P2 `sel=9'h004`: `p2_load`, `card_idx=2`.
   - Exactly 4 REVEAL cycles follow, then `score_pulse`.
   - `match_result=10` → `leader_p2=1`, `round_cnt=2`, `active_p2=1`.
3. **Invalid submissions** in LEAD, P1 hand 1EF.
   - `sel=9'h010` → `err_invalid` pulse, no load, phase 001.
   - `sel=9'h003` → `err_invalid`.
   - `sel=0` → `err_invalid`.
   - Then `sel=9'h001` → `p1_load`, `card_idx=0`.
4. **Held button.** Hold `play_req` high 10 cycles with a valid `sel`. Expect exactly one load pulse and no FOLLOW commit until release and re-press.
5. **Game end.** `ROUNDS=2`, draws throughout. After the second `score_pulse`, phase=101, `round_cnt=2`, `leader_p2=0`. Separately, `game_over=1` in round 1 → DONE after the first SCORE.
6. **Mid-game reset.** Assert `resetn` during REVEAL with the counter at 2. The next cycle shows phase 000, `round_cnt=0`, and no `score_pulse` ever fires.
